rtu_pst_preg_alloc: RTL and testbench

RTU_PST_PREG_ALLOC -- requirements
Module: rtu_pst_preg_alloc

---
 rtl/rtu_pst_preg_alloc_pkg.sv | 24 ++
 rtl/rtu_pst_preg_alloc_if.sv | 33 +++
 rtl/rtu_pst_ff1_rr.sv | 38 +++
 rtl/rtu_pst_preg_alloc.sv | 115 +++++++++++
 tb/tb_rtu_pst_preg_alloc.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rtu_pst_preg_alloc_pkg.sv
// Shared definitions for the physical-register pre-allocator.
// Holds the sizes, the allocator FSM encoding and a one-hot helper used
// by both the allocator and its testbench.
package rtu_pst_preg_alloc_pkg;

    localparam int unsigned PREG_NUM   = 64;
    localparam int unsigned PREG_IDX_W = 6;
    localparam int unsigned PREG_CNT_W = 7;

    // EMPTY: nothing reserved; READY: one preg reserved and offered to IDU
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        READY = 1'b1
    } alloc_state_e;

    // Index to one-hot select over the preg entries
    function automatic logic [PREG_NUM-1:0] idx_onehot(input logic [PREG_IDX_W-1:0] idx);
        logic [PREG_NUM-1:0] one;
        one        = '0;
        one[0]     = 1'b1;
        idx_onehot = one << idx;
    endfunction

endpackage

// File: rtl/rtu_pst_preg_alloc_if.sv
// Bundle between the preg entry array / IDU / RTU flush and the allocator.
//   preg_dealloc_vec : per-entry DEALLOC (free) flag
//   idu_alloc_req    : IDU consumes the offered preg this cycle
//   rtu_global_flush : global flush
//   x_pre_alloc_vld  : one-hot reserve select to an entry (same cycle)
//   x_alloc_vld      : one-hot create strobe to the reserved entry (same cycle)
//   preg_rdy         : a reserved preg is on offer
//   preg_index       : index of the reserved preg
//   preg_free_cnt    : registered popcount of preg_dealloc_vec
// master drives the requests, slave is the allocator.
interface rtu_pst_preg_alloc_if;
    import rtu_pst_preg_alloc_pkg::*;

    logic [PREG_NUM-1:0]   preg_dealloc_vec;
    logic                  idu_alloc_req;
    logic                  rtu_global_flush;
    logic [PREG_NUM-1:0]   x_pre_alloc_vld;
    logic [PREG_NUM-1:0]   x_alloc_vld;
    logic                  preg_rdy;
    logic [PREG_IDX_W-1:0] preg_index;
    logic [PREG_CNT_W-1:0] preg_free_cnt;

    modport master (
        output preg_dealloc_vec, idu_alloc_req, rtu_global_flush,
        input  x_pre_alloc_vld, x_alloc_vld, preg_rdy, preg_index, preg_free_cnt
    );

    modport slave (
        input  preg_dealloc_vec, idu_alloc_req, rtu_global_flush,
        output x_pre_alloc_vld, x_alloc_vld, preg_rdy, preg_index, preg_free_cnt
    );

endinterface

// File: rtl/rtu_pst_ff1_rr.sv
// Rotating find-first-one: first set bit of vec at or above ptr, wrapping
// from the top index back to 0.
//   vec : candidate bit vector
//   ptr : search start position
//   idx : index of the first set bit found (don't-care when !vld)
//   vld : vec has at least one bit set
module rtu_pst_ff1_rr
    import rtu_pst_preg_alloc_pkg::*;
(
    input  logic [PREG_NUM-1:0]   vec,
    input  logic [PREG_IDX_W-1:0] ptr,
    output logic [PREG_IDX_W-1:0] idx,
    output logic                  vld
);

    logic [2*PREG_NUM-1:0] vec_dbl;
    logic [PREG_NUM-1:0]   vec_rot;
    logic [PREG_IDX_W-1:0] offset;

    // Rotate so that bit ptr lands at position 0
    assign vec_dbl = {vec, vec};
    assign vec_rot = vec_dbl[{1'b0, ptr} +: PREG_NUM];

    // Lowest set bit of the rotated vector; scanning downward lets the last hit win
    always_comb begin
        offset = '0;
        for (int k = PREG_NUM - 1; k >= 0; k--) begin
            if (vec_rot[k]) begin
                offset = PREG_IDX_W'(k);
            end
        end
    end

    // Undo the rotation; index arithmetic wraps naturally at 64
    assign idx = ptr + offset;
    assign vld = |vec;

endmodule

// File: rtl/rtu_pst_preg_alloc.sv
// Physical-register pre-allocator. Keeps at most one free preg reserved
// (WF_ALLOC) so IDU can take it with zero latency, and immediately reserves
// the next one round-robin, sustaining one allocation per cycle.
//   clk      : clock, rising edge
//   rst_clk  : asynchronous active-low reset
//   bus      : slave side of rtu_pst_preg_alloc_if (see interface header)
module rtu_pst_preg_alloc
    import rtu_pst_preg_alloc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_clk,
    rtu_pst_preg_alloc_if.slave    bus
);

    alloc_state_e          state_q, state_d;
    logic [PREG_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PREG_IDX_W-1:0] preg_index_q, preg_index_d;
    logic [PREG_CNT_W-1:0] free_cnt_q, free_cnt_d;

    logic [PREG_NUM-1:0]   search_vec;
    logic [PREG_IDX_W-1:0] cand_idx;
    logic                  cand_vld;
    logic                  alloc_fire;
    logic                  pick_en;
    logic [PREG_NUM-1:0]   pre_alloc_vld_c;
    logic [PREG_NUM-1:0]   alloc_vld_c;

    // The reserved entry is not a candidate for its own replacement, which
    // keeps the reserve and create strobes on different entries.
    always_comb begin
        search_vec = bus.preg_dealloc_vec;
        if (state_q == READY) begin
            search_vec[preg_index_q] = 1'b0;
        end
    end

    rtu_pst_ff1_rr u_ff1 (
        .vec (search_vec),
        .ptr (rr_ptr_q),
        .idx (cand_idx),
        .vld (cand_vld)
    );

    // rst_clk gating keeps both strobes quiet while reset is held
    assign alloc_fire = rst_clk && !bus.rtu_global_flush && (state_q == READY) && bus.idu_alloc_req;
    assign pick_en    = rst_clk && !bus.rtu_global_flush && ((state_q == EMPTY) || alloc_fire);

    // Next-state and strobe logic
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        preg_index_d    = preg_index_q;
        pre_alloc_vld_c = '0;
        alloc_vld_c     = '0;

        if (alloc_fire) begin
            alloc_vld_c = idx_onehot(preg_index_q);
        end

        if (pick_en && cand_vld) begin
            pre_alloc_vld_c = idx_onehot(cand_idx);
            preg_index_d    = cand_idx;
            rr_ptr_d        = cand_idx + PREG_IDX_W'(1);
        end

        case (state_q)
            EMPTY: begin
                if (pick_en && cand_vld) begin
                    state_d = READY;
                end
            end
            READY: begin
                // Flush drops the reservation; the entry returns itself to DEALLOC
                if (bus.rtu_global_flush) begin
                    state_d = EMPTY;
                end else if (alloc_fire && !cand_vld) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Popcount of the free flags
    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < PREG_NUM; i++) begin
            free_cnt_d = free_cnt_d + PREG_CNT_W'(bus.preg_dealloc_vec[i]);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            state_q      <= EMPTY;
            rr_ptr_q     <= '0;
            preg_index_q <= '0;
            free_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            preg_index_q <= preg_index_d;
            free_cnt_q   <= free_cnt_d;
        end
    end

    assign bus.x_pre_alloc_vld = pre_alloc_vld_c;
    assign bus.x_alloc_vld     = alloc_vld_c;
    assign bus.preg_rdy        = (state_q == READY);
    assign bus.preg_index      = preg_index_q;
    assign bus.preg_free_cnt   = free_cnt_q;

endmodule

// File: tb/tb_rtu_pst_preg_alloc.sv
module tb_rtu_pst_preg_alloc;
    import rtu_pst_preg_alloc_pkg::*;

    logic clk;
    logic rst_clk;

    rtu_pst_preg_alloc_if bus ();

    rtu_pst_preg_alloc dut (
        .clk     (clk),
        .rst_clk (rst_clk),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [63:0] pre;
        logic [63:0] alloc;
    } exp_comb_t;

    typedef struct {
        logic       rdy;
        logic [5:0] idx;
        logic [6:0] cnt;
    } exp_reg_t;

    exp_comb_t comb_q[$];
    exp_reg_t  reg_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic       m_rdy;
    logic [5:0] m_ptr;
    logic [5:0] m_idx;
    logic [6:0] m_cnt;

    logic [63:0] obs_pre;
    logic [63:0] obs_alloc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bit64(input int n);
        logic [63:0] b;
        b    = '0;
        b[n] = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        m_rdy = 1'b0;
        m_ptr = '0;
        m_idx = '0;
        m_cnt = '0;
    endtask

    // One clock cycle: drive just after a falling edge, check strobes, then registered outputs
    task automatic run_cycle(input string tag, input logic [63:0] v, input logic r, input logic f);
        logic       fire, en, found;
        logic [5:0] cand;
        logic [63:0] masked;
        exp_comb_t  ec, gc;
        exp_reg_t   er, gr;

        bus.preg_dealloc_vec = v;
        bus.idu_alloc_req    = r;
        bus.rtu_global_flush = f;

        fire   = m_rdy && r && !f;
        en     = !f && (!m_rdy || fire);
        masked = v;
        if (m_rdy) masked[m_idx] = 1'b0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < 64; k++) begin
            int j;
            j = (int'(m_ptr) + k) % 64;
            if (!found && masked[j]) begin
                found = 1'b1;
                cand  = 6'(j);
            end
        end

        ec.pre   = (en && found) ? bit64(int'(cand)) : 64'd0;
        ec.alloc = fire ? bit64(int'(m_idx)) : 64'd0;
        comb_q.push_back(ec);

        er.rdy = f ? 1'b0 : (!m_rdy ? found : (r ? found : 1'b1));
        er.idx = (en && found) ? cand : m_idx;
        er.cnt = 7'($countones(v));
        reg_q.push_back(er);

        #1;
        if (comb_q.size() > 0) begin
            gc        = comb_q.pop_front();
            obs_pre   = bus.x_pre_alloc_vld;
            obs_alloc = bus.x_alloc_vld;
            check({tag, ".pre"},   obs_pre,   gc.pre);
            check({tag, ".alloc"}, obs_alloc, gc.alloc);
        end

        @(posedge clk);
        m_rdy = er.rdy;
        m_idx = er.idx;
        if (en && found) m_ptr = cand + 6'd1;
        m_cnt = er.cnt;

        @(negedge clk);
        if (reg_q.size() > 0) begin
            gr = reg_q.pop_front();
            check({tag, ".rdy"}, 64'(bus.preg_rdy),      64'(gr.rdy));
            check({tag, ".idx"}, 64'(bus.preg_index),    64'(gr.idx));
            check({tag, ".cnt"}, 64'(bus.preg_free_cnt), 64'(gr.cnt));
        end
    endtask

    initial begin
        logic [63:0] v;
        logic        r, f;

        model_reset();
        rst_clk              = 1'b0;
        bus.preg_dealloc_vec = 64'hFFFF_FFFF_0000_0000;
        bus.idu_alloc_req    = 1'b0;
        bus.rtu_global_flush = 1'b0;

        // Reset state with a non-zero free vector present
        @(negedge clk);
        #1;
        check("rst.pre",   bus.x_pre_alloc_vld, 64'd0);
        check("rst.alloc", bus.x_alloc_vld,     64'd0);
        check("rst.rdy",   64'(bus.preg_rdy),      64'd0);
        check("rst.idx",   64'(bus.preg_index),    64'd0);
        check("rst.cnt",   64'(bus.preg_free_cnt), 64'd0);
        @(negedge clk);

        // First pick in the first cycle after release
        rst_clk = 1'b1;
        run_cycle("rel", 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);
        check("rel.pre32", obs_pre, 64'h0000_0001_0000_0000);
        check("rel.idx32", 64'(bus.preg_index), 64'd32);
        check("rel.rdy1",  64'(bus.preg_rdy),   64'd1);
        check("rel.cnt32", 64'(bus.preg_free_cnt), 64'd32);

        // Back-to-back allocation
        v = bit64(33) | bit64(34) | bit64(40);
        run_cycle("b2b0", v, 1'b1, 1'b0);
        check("b2b0.a32", obs_alloc, bit64(32));
        check("b2b0.p33", obs_pre,   bit64(33));
        run_cycle("b2b1", v, 1'b1, 1'b0);
        check("b2b1.a33", obs_alloc, bit64(33));
        check("b2b1.p34", obs_pre,   bit64(34));
        run_cycle("b2b2", v, 1'b1, 1'b0);
        check("b2b2.a34", obs_alloc, bit64(34));
        check("b2b2.p40", obs_pre,   bit64(40));

        // Flush beats a simultaneous request; repick keeps the pointer (41)
        run_cycle("fl", bit64(5) | bit64(45), 1'b1, 1'b1);
        check("fl.alloc0", obs_alloc, 64'd0);
        check("fl.pre0",   obs_pre,   64'd0);
        check("fl.rdy0",   64'(bus.preg_rdy), 64'd0);
        run_cycle("flr", bit64(5) | bit64(45), 1'b0, 1'b0);
        check("flr.p45", obs_pre, bit64(45));

        // Wrap-around from pointer 63
        run_cycle("wr0", bit64(62), 1'b1, 1'b0);
        check("wr0.p62", obs_pre, bit64(62));
        run_cycle("wr1", bit64(2), 1'b1, 1'b0);
        check("wr1.a62", obs_alloc, bit64(62));
        check("wr1.p2",  obs_pre,   bit64(2));
        run_cycle("wr2", bit64(1) | bit64(3), 1'b1, 1'b0);
        check("wr2.p3",  obs_pre,   bit64(3));

        // Drain with no free pregs, then requests in EMPTY are ignored
        run_cycle("dr0", 64'd0, 1'b1, 1'b0);
        check("dr0.a3",   obs_alloc, bit64(3));
        check("dr0.rdy0", 64'(bus.preg_rdy), 64'd0);
        run_cycle("dr1", 64'd0, 1'b1, 1'b0);
        check("dr1.alloc0", obs_alloc, 64'd0);
        run_cycle("dr2", 64'd0, 1'b1, 1'b0);
        run_cycle("dr3", bit64(10), 1'b1, 1'b0);
        check("dr3.alloc0", obs_alloc, 64'd0);
        check("dr3.p10",    obs_pre,   bit64(10));

        // Popcount extremes; reservation held without requests
        run_cycle("pc0", '1, 1'b0, 1'b0);
        check("pc0.cnt64", 64'(bus.preg_free_cnt), 64'd64);
        check("pc0.pre0",  obs_pre, 64'd0);
        run_cycle("pc1", 64'd0, 1'b0, 1'b0);
        check("pc1.cnt0",  64'(bus.preg_free_cnt), 64'd0);
        check("pc1.idx10", 64'(bus.preg_index), 64'd10);

        // Reset mid-operation, asserted between edges
        bus.preg_dealloc_vec = bit64(20);
        bus.idu_alloc_req    = 1'b1;
        #2;
        rst_clk = 1'b0;
        #1;
        check("mr.rdy",   64'(bus.preg_rdy),      64'd0);
        check("mr.pre",   bus.x_pre_alloc_vld,    64'd0);
        check("mr.alloc", bus.x_alloc_vld,        64'd0);
        check("mr.idx",   64'(bus.preg_index),    64'd0);
        check("mr.cnt",   64'(bus.preg_free_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_clk = 1'b1;
        run_cycle("mr0", 64'd0, 1'b0, 1'b0);
        check("mr0.pre0", obs_pre, 64'd0);
        run_cycle("mr1", bit64(7), 1'b0, 1'b0);
        check("mr1.p7", obs_pre, bit64(7));

        // Randomised traffic against the model
        for (int n = 0; n < 200; n++) begin
            v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) v = 64'd0;
            if ($urandom_range(0, 15) == 0) v = bit64(int'($urandom_range(0, 63)));
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 15) == 0);
            run_cycle("rnd", v, r, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
